// File: rtl/mem_req_ctrl.sv
// Load/store request controller between the execute stage and DATA_RAM.
// Moore FSM: checks each accepted op, issues one RAM start, returns a writeback or an exception.
module mem_req_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_imm,
  input  logic [4:0]  req_rd,
  output logic        ram_start,
  output logic [31:0] ram_op1,
  output logic [31:0] ram_op2,
  output logic [31:0] ram_imm_data,
  output logic [1:0]  ram_use_part,
  output logic [1:0]  ram_op_mode1,
  output logic [2:0]  ram_op_mode2,
  input  logic        ram_done,
  input  logic [31:0] ram_res,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic [31:0] rs1_l, rs2_l, imm_l, ea_l, res_l;
  logic [2:0]  f3_l;
  logic        store_l;
  logic [4:0]  rd_l;
  logic [1:0]  cause_l;

  logic [31:0] ea;
  logic        illegal, misaligned, accept, timeout;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  load_ext = {24'd0, d[7:0]};
      3'b101:  load_ext = {16'd0, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  assign ea         = req_rs1 + req_imm;
  assign illegal    = req_is_store ? (req_funct3 >= 3'b011)
                                   : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign misaligned = (req_funct3[1:0] == 2'b01 && ea[0]) ||
                      (req_funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
  assign accept     = (state == IDLE) && req_valid;
  // Counter is compared before increment, so the ERR edge lands TIMEOUT_CYCLES edges after the start edge.
  assign timeout    = (state == WAIT) && !ram_done && (cnt == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (req_valid) state_nxt = (illegal || misaligned) ? ERR : ISSUE;
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (ram_done)     state_nxt = RESP;
        else if (timeout) state_nxt = ERR;
        else              cnt_nxt   = cnt + 1'b1;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rs1_l   <= req_rs1;
      rs2_l   <= req_rs2;
      imm_l   <= req_imm;
      ea_l    <= ea;
      f3_l    <= req_funct3;
      store_l <= req_is_store;
      rd_l    <= req_rd;
      cause_l <= illegal ? 2'b01 : 2'b00;
    end
    if (state == WAIT && ram_done) res_l <= ram_res;
    if (timeout) cause_l <= 2'b10;
  end

  logic ram_act;
  assign ram_act = (state == ISSUE) || (state == WAIT);

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign ram_start    = (state == ISSUE);
  assign ram_op1      = ram_act ? rs1_l : 32'd0;
  assign ram_op2      = ram_act ? rs2_l : 32'd0;
  assign ram_imm_data = ram_act ? imm_l : 32'd0;
  assign ram_use_part = ram_act ? f3_l[1:0] : 2'b00;
  assign ram_op_mode1 = (ram_act && store_l) ? 2'b01 : 2'b00;
  assign ram_op_mode2 = ram_act ? f3_l : 3'b000;

  assign wb_valid  = (state == RESP);
  assign wb_we     = wb_valid && !store_l && (rd_l != 5'd0);
  assign wb_rd     = wb_valid ? rd_l : 5'd0;
  assign wb_data   = (wb_valid && !store_l) ? load_ext(f3_l, res_l) : 32'd0;

  assign exc_valid = (state == ERR);
  assign exc_cause = exc_valid ? cause_l : 2'b00;
  assign exc_addr  = exc_valid ? ea_l : 32'd0;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: hand-computed load/store, exception, timeout and reset cases.
module tb_mem_req_ctrl;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_imm = '0;
  logic [4:0]  req_rd = '0;
  logic        ram_start, ram_done = 1'b0;
  logic [31:0] ram_op1, ram_op2, ram_imm_data, ram_res = '0;
  logic [1:0]  ram_use_part, ram_op_mode1;
  logic [2:0]  ram_op_mode2;
  logic        wb_valid, wb_we, exc_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;

  int n_vec = 0;
  int n_bad = 0;

  mem_req_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_rd(req_rd), .ram_start(ram_start),
    .ram_op1(ram_op1), .ram_op2(ram_op2), .ram_imm_data(ram_imm_data),
    .ram_use_part(ram_use_part), .ram_op_mode1(ram_op_mode1), .ram_op_mode2(ram_op_mode2),
    .ram_done(ram_done), .ram_res(ram_res), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_addr(exc_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one request for a single edge; returns at the negedge after the accept edge.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  // Starts in ISSUE; raises done for one cycle at wait-step `delay`; returns when wb/exc seen.
  task automatic wait_resp(input int delay, input logic [31:0] res, output int starts);
    int cyc;
    cyc = 0; starts = 0;
    ram_res = res;
    while (cyc < 40 && !wb_valid && !exc_valid) begin
      if (ram_start) starts++;
      ram_done = (cyc == delay);
      tick();
      cyc++;
    end
    ram_done = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [4:0] rd,
                           input logic [31:0] res, input logic [31:0] exp_data,
                           input logic exp_we);
    int starts;
    send(1'b0, f3, rs1, 32'h0, imm, rd);
    chk({tag, "_start"}, 32'(ram_start), 32'd1);
    chk({tag, "_op1"}, ram_op1, rs1);
    wait_resp(2, res, starts);
    chk({tag, "_nstart"}, 32'(starts), 32'd1);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_we"}, 32'(wb_we), 32'(exp_we));
    chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, "_data"}, wb_data, exp_data);
    tick();
  endtask

  initial begin
    int starts;
    int n;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(ram_start), 32'd0);
    chk("rst_op1", ram_op1, 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_exc", 32'(exc_valid), 32'd0);
    rst = 1'b1;
    tick();

    // 1) LW, done 3 cycles after start
    send(1'b0, 3'b010, 32'h100, 32'h0, 32'h4, 5'd5);
    chk("lw_start", 32'(ram_start), 32'd1);
    chk("lw_part", 32'(ram_use_part), 32'd2);
    chk("lw_imm", ram_imm_data, 32'h4);
    chk("lw_mode1", 32'(ram_op_mode1), 32'd0);
    chk("lw_mode2", 32'(ram_op_mode2), 32'd2);
    chk("lw_ready", 32'(req_ready), 32'd0);
    wait_resp(3, 32'hDEADBEEF, starts);
    chk("lw_nstart", 32'(starts), 32'd1);
    chk("lw_wbv", 32'(wb_valid), 32'd1);
    chk("lw_exc", 32'(exc_valid), 32'd0);
    chk("lw_we", 32'(wb_we), 32'd1);
    chk("lw_rd", 32'(wb_rd), 32'd5);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_ready_resp", 32'(req_ready), 32'd0);
    tick();
    chk("lw_wbv_off", 32'(wb_valid), 32'd0);
    chk("lw_ready_back", 32'(req_ready), 32'd1);
    chk("lw_op1_zero", ram_op1, 32'd0);

    // 2) Byte/half extension
    load_case("lb",  3'b000, 32'h200, 32'h3, 5'd7, 32'h00000080, 32'hFFFFFF80, 1'b1);
    load_case("lbu", 3'b100, 32'h200, 32'h3, 5'd7, 32'h00000080, 32'h00000080, 1'b1);
    load_case("lh",  3'b001, 32'h200, 32'h2, 5'd8, 32'h00018000, 32'hFFFF8000, 1'b1);
    load_case("lhu", 3'b101, 32'h200, 32'h2, 5'd8, 32'h00018000, 32'h00008000, 1'b1);

    // SW success: store data reaches RAM, writeback carries no data
    send(1'b1, 3'b010, 32'h300, 32'h12345678, 32'h8, 5'd9);
    chk("sw_mode1", 32'(ram_op_mode1), 32'd1);
    chk("sw_op2", ram_op2, 32'h12345678);
    wait_resp(1, 32'hFFFFFFFF, starts);
    chk("sw_wbv", 32'(wb_valid), 32'd1);
    chk("sw_we", 32'(wb_we), 32'd0);
    chk("sw_data", wb_data, 32'd0);
    tick();

    // 3) SH misaligned
    send(1'b1, 3'b001, 32'h1000, 32'h0, 32'h1, 5'd0);
    chk("sh_exc", 32'(exc_valid), 32'd1);
    chk("sh_cause", 32'(exc_cause), 32'd0);
    chk("sh_addr", exc_addr, 32'h1001);
    chk("sh_start", 32'(ram_start), 32'd0);
    chk("sh_wbv", 32'(wb_valid), 32'd0);
    tick();
    chk("sh_exc_off", 32'(exc_valid), 32'd0);
    chk("sh_ready", 32'(req_ready), 32'd1);

    // LW misaligned by one halfword
    send(1'b0, 3'b010, 32'h100, 32'h0, 32'h2, 5'd3);
    chk("lwmis_exc", 32'(exc_valid), 32'd1);
    chk("lwmis_cause", 32'(exc_cause), 32'd0);
    tick();

    // 4) SW timeout, then a late done in IDLE
    send(1'b1, 3'b010, 32'h400, 32'hAA, 32'h10, 5'd0);
    chk("to_start", 32'(ram_start), 32'd1);
    n = 0;
    while (!exc_valid && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
    chk("to_cause", 32'(exc_cause), 32'd2);
    chk("to_addr", exc_addr, 32'h410);
    chk("to_wbv", 32'(wb_valid), 32'd0);
    tick();
    ram_done = 1'b1; ram_res = 32'h55;
    tick();
    ram_done = 1'b0;
    chk("late_wbv", 32'(wb_valid), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    tick();
    chk("late_wbv2", 32'(wb_valid), 32'd0);

    // 5) rd=0 load, illegal funct3
    load_case("lw_x0", 3'b010, 32'h100, 32'h0, 5'd0, 32'h11223344, 32'h11223344, 1'b0);
    send(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd1);
    chk("ill_ld_exc", 32'(exc_valid), 32'd1);
    chk("ill_ld_cause", 32'(exc_cause), 32'd1);
    tick();
    send(1'b1, 3'b011, 32'h100, 32'h0, 32'h1, 5'd0);
    chk("ill_st_cause", 32'(exc_cause), 32'd1);
    chk("ill_st_addr", exc_addr, 32'h101);
    tick();

    // 6) Reset during WAIT
    send(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 5'd4);
    tick(); tick();
    chk("rw_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_ready", 32'(req_ready), 32'd1);
    chk("rw_op1", ram_op1, 32'd0);
    chk("rw_exc", 32'(exc_valid), 32'd0);
    ram_done = 1'b1; ram_res = 32'h77;
    tick();
    ram_done = 1'b0;
    chk("rw_wbv", 32'(wb_valid), 32'd0);
    tick();
    chk("rw_wbv2", 32'(wb_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
